// File: rtl/spart_pkg.sv
// Shared SPART bus constants and receive-queue FSM state type.
package spart_pkg;

  localparam logic [1:0] SPART_ADDR_BUF = 2'b00;
  localparam logic       SPART_RD       = 1'b1;
  localparam logic       SPART_WR       = 1'b0;
  localparam logic [7:0] OVF_CNT_MAX    = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RELEASE
  } rxq_state_t;

endpackage

// File: rtl/spart_rx_queue_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered count/full/empty.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_LAST = (AW + 1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is left unreset; the output is forced to zero while empty instead.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10: begin
          count <= count + 1'b1;
          full  <= (count == CNT_LAST);
          empty <= 1'b0;
        end
        2'b01: begin
          count <= count - 1'b1;
          full  <= 1'b0;
          empty <= (count == CNT_ONE);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/spart_rx_queue.sv
// Drains received bytes from a SPART into a FWFT valid/ready queue.
// Define SPART_RXQ_OVF_DROP_EN to keep draining while full and count dropped bytes.
module spart_rx_queue
  import spart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rda,
  output logic                   iocs,
  output logic                   iorw,
  output logic [1:0]             ioaddr,
  inout  wire  [7:0]             databus,
  output logic [7:0]             m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
`ifdef SPART_RXQ_OVF_DROP_EN
  ,
  output logic [7:0]             ovf_cnt
`endif
);

  rxq_state_t state;
  rxq_state_t state_next;
  logic       permit;
  logic       push;
  logic       fifo_empty;

  assign databus = 'z;
  assign iorw    = SPART_RD;
  assign ioaddr  = SPART_ADDR_BUF;

`ifdef SPART_RXQ_OVF_DROP_EN
  assign permit = 1'b1;
`else
  assign permit = !full;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    iocs       = 1'b0;
    unique case (state)
      IDLE: begin
        if (rda && permit) begin
          state_next = READ;
        end
      end
      READ: begin
        iocs       = 1'b1;
        state_next = RELEASE;
      end
      RELEASE: begin
        if (!rda) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The byte is captured on the edge that ends READ; a full queue discards it.
  assign push = (state == READ) && !full;

`ifdef SPART_RXQ_OVF_DROP_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_cnt <= '0;
    end else if ((state == READ) && full && (ovf_cnt != OVF_CNT_MAX)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end
`endif

  sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (m_ready),
    .din  (databus),
    .dout (m_data),
    .count(count),
    .full (full),
    .empty(fifo_empty)
  );

  assign m_valid = !fifo_empty;

endmodule

// File: tb/tb_spart_rx_queue.sv
// Self-checking bench for spart_rx_queue with a behavioural SPART receive model.
module tb_spart_rx_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rda;
  logic          iocs;
  logic          iorw;
  logic [1:0]    ioaddr;
  wire  [7:0]    databus;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] count;
  logic          full;
`ifdef SPART_RXQ_OVF_DROP_EN
  logic [7:0]    ovf_cnt;
`endif

  logic [7:0]    cur_byte = 8'h00;
  logic [7:0]    tx_q[$];
  logic [7:0]    exp_q[$];
  int unsigned   exp_ovf = 0;
  int unsigned   gap = 1;
  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;

  typedef struct {
    logic [7:0]  first;
    int unsigned n;
    int unsigned exp_count;
    bit          exp_full;
  } vec_t;

  vec_t vecs[3];

  spart_rx_queue #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .rda    (rda),
    .iocs   (iocs),
    .iorw   (iorw),
    .ioaddr (ioaddr),
    .databus(databus),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .count  (count),
    .full   (full)
`ifdef SPART_RXQ_OVF_DROP_EN
    ,
    .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign databus = (iocs && iorw) ? cur_byte : 'z;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] first, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      tx_q.push_back(first + 8'(i));
    end
  endtask

  // Scoreboard and SPART model, sampled mid-cycle.
  always @(negedge clk) begin
    bit accept;
    if (rst) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
      chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
`ifdef SPART_RXQ_OVF_DROP_EN
      chk("ovf_cnt", 32'(ovf_cnt), exp_ovf);
`else
      if (full) chk("iocs_while_full", 32'(iocs), 0);
`endif
      if (iocs) begin
        chk("iorw", 32'(iorw), 1);
        chk("ioaddr", 32'(ioaddr), 0);
      end
      accept = iocs && (exp_q.size() < DEPTH);
      if (m_ready && exp_q.size() != 0) begin
        chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      if (accept) exp_q.push_back(cur_byte);
      else if (iocs && exp_ovf < 255) exp_ovf++;
    end
    if (iocs) begin
      rda = 1'b0;
      gap = 0;
    end else if (!rda) begin
      if (gap >= 1 && tx_q.size() != 0) begin
        cur_byte = tx_q.pop_front();
        rda      = 1'b1;
      end else if (gap < 2) begin
        gap++;
      end
    end
  end

  task automatic drain(input string name);
    int unsigned t = 0;
    m_ready = 1'b1;
    while (!(tx_q.size() == 0 && !rda && !iocs && !m_valid) && t < 600) begin
      @(posedge clk);
      #1;
      t++;
    end
    m_ready = 1'b0;
    chk({name, "_drain_done"}, 32'(t < 600), 1);
    chk({name, "_drain_count"}, 32'(count), 0);
  endtask

  task automatic wait_read(input string name);
    int unsigned t = 0;
    while (!iocs && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({name, "_read_seen"}, 32'(iocs), 1);
  endtask

  initial begin
    bit hit;
    rst     = 1'b0;
    rda     = 1'b0;
    m_ready = 1'b0;
    vecs[0] = '{first: 8'h01, n: 5,  exp_count: 5,  exp_full: 1'b0};
    vecs[1] = '{first: 8'h40, n: 16, exp_count: 16, exp_full: 1'b1};
    vecs[2] = '{first: 8'hC0, n: 3,  exp_count: 3,  exp_full: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_iocs", 32'(iocs), 0);
    chk("rst_iorw", 32'(iorw), 1);
    chk("rst_ioaddr", 32'(ioaddr), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_m_data", 32'(m_data), 0);
`ifdef SPART_RXQ_OVF_DROP_EN
    chk("rst_ovf_cnt", 32'(ovf_cnt), 0);
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single byte latency: READ the cycle after rda is seen, valid the cycle after.
    send(8'hAB, 1);
    hit = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      @(posedge clk);
      if (rda) begin
        hit = 1'b1;
        break;
      end
    end
    #1;
    chk("lat_rda_seen", 32'(hit), 1);
    chk("lat_iocs", 32'(iocs), 1);
    @(posedge clk);
    #1;
    chk("lat_iocs_off", 32'(iocs), 0);
    chk("lat_m_valid", 32'(m_valid), 1);
    chk("lat_m_data", 32'(m_data), 32'h AB);
    chk("lat_count", 32'(count), 1);
    drain("lat");

    for (int unsigned v = 0; v < 3; v++) begin
      send(vecs[v].first, vecs[v].n);
      repeat (vecs[v].n * 3 + 8) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_count", v), 32'(count), vecs[v].exp_count);
      chk($sformatf("vec%0d_full", v), 32'(full), 32'(vecs[v].exp_full));
      chk($sformatf("vec%0d_m_data", v), 32'(m_data), 32'(vecs[v].first));
      drain($sformatf("vec%0d", v));
    end

    // Overfill by two bytes, then pop once while the FSM is waiting in IDLE.
    send(8'h80, DEPTH + 2);
    repeat ((DEPTH + 2) * 3 + 10) @(posedge clk);
    #1;
    chk("ovf_count", 32'(count), DEPTH);
    chk("ovf_full", 32'(full), 1);
`ifdef SPART_RXQ_OVF_DROP_EN
    chk("ovf_cnt_two", 32'(ovf_cnt), 2);
    chk("ovf_rda_low", 32'(rda), 0);
`else
    chk("ovf_rda_high", 32'(rda), 1);
    chk("ovf_tx_pending", 32'(tx_q.size()), 1);
`endif
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    chk("pop_full_iocs", 32'(iocs), 0);
    chk("pop_full_count", 32'(count), DEPTH - 1);
    @(posedge clk);
    #1;
`ifdef SPART_RXQ_OVF_DROP_EN
    chk("pop_full_relaunch", 32'(iocs), 0);
    @(posedge clk);
    #1;
    chk("pop_full_refill", 32'(count), DEPTH - 1);
`else
    chk("pop_full_relaunch", 32'(iocs), 1);
    @(posedge clk);
    #1;
    chk("pop_full_refill", 32'(count), DEPTH);
    chk("pop_full_m_data", 32'(m_data), 32'h 81);
`endif
    drain("ovf");

    // Push and pop on the same edge at occupancy two.
    send(8'h10, 2);
    repeat (12) @(posedge clk);
    #1;
    chk("pp_pre_count", 32'(count), 2);
    send(8'h12, 1);
    wait_read("pp");
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    chk("pp_count", 32'(count), 2);
    chk("pp_head", 32'(m_data), 32'h 11);
    drain("pp");

    // Reset asserted during READ discards everything.
    send(8'h20, 2);
    repeat (12) @(posedge clk);
    #1;
    send(8'h22, 1);
    wait_read("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_iocs", 32'(iocs), 0);
    chk("rst_mid_count", 32'(count), 0);
    chk("rst_mid_m_valid", 32'(m_valid), 0);
    chk("rst_mid_full", 32'(full), 0);
    exp_q.delete();
    exp_ovf = 0;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(8'h5A, 1);
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_m_data", 32'(m_data), 32'h 5A);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
